// File: rtl/vjtag_bus_arb.sv
// vjtag_bus_arb: shares one downstream bus between the VJTAG host (master 0)
// and a second on-chip requester (master 1). One transaction is in flight at a
// time; read responses are routed back to the issuing master, and reads that
// never return are completed with all-ones data after RSP_TIMEOUT cycles.
// Optional feature macro: VJTAG_ARB_RR_EN selects round-robin arbitration;
// when it is undefined, master 0 wins every tie.
module vjtag_bus_arb #(
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 16,
  parameter int RSP_TIMEOUT = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  m0_req_valid,
  input  logic [ADDR_WIDTH-1:0] m0_req_addr,
  input  logic                  m0_req_write,
  input  logic [DATA_WIDTH-1:0] m0_req_wdata,
  output logic                  m0_req_ready,
  output logic                  m0_rsp_valid,
  output logic [DATA_WIDTH-1:0] m0_rsp_rdata,
  input  logic                  m1_req_valid,
  input  logic [ADDR_WIDTH-1:0] m1_req_addr,
  input  logic                  m1_req_write,
  input  logic [DATA_WIDTH-1:0] m1_req_wdata,
  output logic                  m1_req_ready,
  output logic                  m1_rsp_valid,
  output logic [DATA_WIDTH-1:0] m1_rsp_rdata,
  output logic                  s_req_valid,
  output logic [ADDR_WIDTH-1:0] s_req_addr,
  output logic                  s_req_write,
  output logic [DATA_WIDTH-1:0] s_req_wdata,
  input  logic                  s_req_ready,
  input  logic                  s_rsp_valid,
  input  logic [DATA_WIDTH-1:0] s_rsp_rdata,
  output logic                  gnt_id,
  output logic                  busy,
  output logic                  timeout_err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_RSP   = 2'd2
  } state_t;

  // A zero RSP_TIMEOUT disables the timeout; keep the counter at least 1 bit.
  localparam bit TO_EN   = (RSP_TIMEOUT > 0);
  localparam int CNT_W   = TO_EN ? $clog2(RSP_TIMEOUT + 1) : 1;
  localparam int TO_LAST = TO_EN ? RSP_TIMEOUT - 1 : 0;

  state_t                  state;
  logic [CNT_W-1:0]        to_cnt;
  logic                    any_req;
  logic                    win;
  logic                    sel_valid;
  logic                    sel_write;
  logic [ADDR_WIDTH-1:0]   sel_addr;
  logic [DATA_WIDTH-1:0]   sel_wdata;
  logic                    in_grant;
  logic                    in_rsp;
  logic                    timeout_hit;
  logic                    rsp_fire;
  logic [DATA_WIDTH-1:0]   rsp_data;

  assign any_req  = m0_req_valid | m1_req_valid;
  assign in_grant = (state == S_GRANT);
  assign in_rsp   = (state == S_RSP);

`ifdef VJTAG_ARB_RR_EN
  logic last_gnt;

  // Round-robin winner: a tie goes to the master that was not granted last.
  always_comb begin
    win = 1'b0;
    if (m0_req_valid && m1_req_valid) win = ~last_gnt;
    else                              win = ~m0_req_valid;
  end

  // Remember who was granted so the next tie goes the other way.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          last_gnt <= 1'b1;
    else if (state == S_IDLE && any_req) last_gnt <= win;
  end
`else
  // Fixed priority winner: the VJTAG host wins whenever it is requesting.
  always_comb begin
    win = ~m0_req_valid;
  end
`endif

  // Select the granted master's request fields.
  always_comb begin
    sel_valid = gnt_id ? m1_req_valid : m0_req_valid;
    sel_write = gnt_id ? m1_req_write : m0_req_write;
    sel_addr  = gnt_id ? m1_req_addr  : m0_req_addr;
    sel_wdata = gnt_id ? m1_req_wdata : m0_req_wdata;
  end

  // Response completes on a real response (which wins over a same-cycle timeout)
  // or on the last allowed RSP cycle without one.
  assign timeout_hit = TO_EN && in_rsp && !s_rsp_valid && (to_cnt == CNT_W'(TO_LAST));
  assign rsp_fire    = in_rsp && (s_rsp_valid || timeout_hit);
  assign rsp_data    = timeout_hit ? {DATA_WIDTH{1'b1}} : s_rsp_rdata;

  // Downstream request, master readies and response routing.
  always_comb begin
    s_req_valid  = in_grant & sel_valid;
    s_req_write  = in_grant & sel_write;
    s_req_addr   = in_grant ? sel_addr  : '0;
    s_req_wdata  = in_grant ? sel_wdata : '0;
    m0_req_ready = in_grant & ~gnt_id & s_req_ready;
    m1_req_ready = in_grant &  gnt_id & s_req_ready;
    m0_rsp_valid = rsp_fire & ~gnt_id;
    m1_rsp_valid = rsp_fire &  gnt_id;
    m0_rsp_rdata = rsp_data;
    m1_rsp_rdata = rsp_data;
    timeout_err  = timeout_hit;
    busy         = (state != S_IDLE);
  end

  // Arbitration FSM with grant register and saturating response timer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      gnt_id <= 1'b0;
      to_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (any_req) begin
            gnt_id <= win;
            state  <= S_GRANT;
          end
        end
        S_GRANT: begin
          if (!sel_valid) begin
            state <= S_IDLE;
          end else if (s_req_ready) begin
            if (sel_write) begin
              state <= S_IDLE;
            end else begin
              to_cnt <= '0;
              state  <= S_RSP;
            end
          end
        end
        S_RSP: begin
          if (rsp_fire)          state  <= S_IDLE;
          else if (to_cnt != '1) to_cnt <= to_cnt + 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vjtag_bus_arb.sv
// tb_vjtag_bus_arb: randomized two-master traffic against a transaction-level
// reference model, plus directed reset and tie sequences.
module tb_vjtag_bus_arb;

  localparam int AW = 16;
  localparam int DW = 16;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          m0_req_valid = 1'b0, m1_req_valid = 1'b0;
  logic [AW-1:0] m0_req_addr = '0, m1_req_addr = '0;
  logic          m0_req_write = 1'b0, m1_req_write = 1'b0;
  logic [DW-1:0] m0_req_wdata = '0, m1_req_wdata = '0;
  logic          m0_req_ready, m1_req_ready, m0_rsp_valid, m1_rsp_valid;
  logic [DW-1:0] m0_rsp_rdata, m1_rsp_rdata;
  logic          s_req_valid, s_req_write;
  logic [AW-1:0] s_req_addr;
  logic [DW-1:0] s_req_wdata;
  logic          s_req_ready = 1'b0, s_rsp_valid = 1'b0;
  logic [DW-1:0] s_rsp_rdata = '0;
  logic          gnt_id, busy, timeout_err;

  vjtag_bus_arb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RSP_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req_valid(m0_req_valid), .m0_req_addr(m0_req_addr), .m0_req_write(m0_req_write),
    .m0_req_wdata(m0_req_wdata), .m0_req_ready(m0_req_ready), .m0_rsp_valid(m0_rsp_valid),
    .m0_rsp_rdata(m0_rsp_rdata),
    .m1_req_valid(m1_req_valid), .m1_req_addr(m1_req_addr), .m1_req_write(m1_req_write),
    .m1_req_wdata(m1_req_wdata), .m1_req_ready(m1_req_ready), .m1_rsp_valid(m1_rsp_valid),
    .m1_rsp_rdata(m1_rsp_rdata),
    .s_req_valid(s_req_valid), .s_req_addr(s_req_addr), .s_req_write(s_req_write),
    .s_req_wdata(s_req_wdata), .s_req_ready(s_req_ready), .s_rsp_valid(s_rsp_valid),
    .s_rsp_rdata(s_rsp_rdata), .gnt_id(gnt_id), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct { logic [AW-1:0] addr; logic write; logic [DW-1:0] wdata; } req_t;
  typedef struct { logic [DW-1:0] data; logic to; int cyc; } rsp_t;

  req_t req_q0[$], req_q1[$];
  rsp_t rsp_q0[$], rsp_q1[$];

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  bit   stim_done = 1'b0;
  logic cur_gnt = 1'b0;   // model's grant for the current transaction
  logic mdl_last = 1'b1;  // model's last granted master
  bit   arb_pending = 1'b0;
  logic arb_exp = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Arbitration model: a request seen while idle must be granted on the next
  // cycle to the master the policy picks.
  always @(negedge clk) begin
    if (!rst_n) begin
      mdl_last    = 1'b1;
      arb_pending = 1'b0;
    end else if (arb_pending) begin
      check("grant_busy", busy, 1'b1);
      check("grant_id", gnt_id, arb_exp);
      arb_pending = 1'b0;
    end else if (!busy && (m0_req_valid || m1_req_valid)) begin
      if (m0_req_valid && m1_req_valid) begin
`ifdef VJTAG_ARB_RR_EN
        arb_exp = (mdl_last == 1'b1) ? 1'b0 : 1'b1;
`else
        arb_exp = 1'b0;
`endif
      end else begin
        arb_exp = m1_req_valid && !m0_req_valid;
      end
      mdl_last    = arb_exp;
      cur_gnt     = arb_exp;
      arb_pending = 1'b1;
    end
  end

  task automatic pop_rsp(input int n, input logic [DW-1:0] rdata);
    rsp_t e;
    if ((n == 0 && rsp_q0.size() == 0) || (n == 1 && rsp_q1.size() == 0)) begin
      check($sformatf("rsp_unexpected_m%0d", n), 1, 0);
    end else begin
      e = (n == 0) ? rsp_q0.pop_front() : rsp_q1.pop_front();
      check($sformatf("rsp_rdata_m%0d", n), rdata, e.data);
      check($sformatf("rsp_timeout_err_m%0d", n), timeout_err, e.to);
      check($sformatf("rsp_cycle_m%0d", n), cyc, e.cyc);
    end
  endtask

  // Response monitor: every response must match the oldest expected one for that master.
  always @(negedge clk) begin
    if (rst_n) begin
      if (m0_rsp_valid) pop_rsp(0, m0_rsp_rdata);
      if (m1_rsp_valid) pop_rsp(1, m1_rsp_rdata);
      if (timeout_err && !m0_rsp_valid && !m1_rsp_valid) check("timeout_err_alone", 1, 0);
    end
  end

  task automatic drive_master(input int n, input int count);
    for (int i = 0; i < count; i++) begin
      req_t r;
      bit   got;
      repeat ($urandom_range(0, 3)) @(posedge clk);
      @(posedge clk); #1;
      r.addr  = AW'($urandom);
      r.write = 1'($urandom_range(0, 1));
      r.wdata = DW'($urandom);
      if (n == 0) begin
        m0_req_valid = 1'b1; m0_req_addr = r.addr; m0_req_write = r.write; m0_req_wdata = r.wdata;
        req_q0.push_back(r);
      end else begin
        m1_req_valid = 1'b1; m1_req_addr = r.addr; m1_req_write = r.write; m1_req_wdata = r.wdata;
        req_q1.push_back(r);
      end
      got = 1'b0;
      for (int w = 0; w < 300 && !got; w++) begin
        @(negedge clk);
        got = (n == 0) ? m0_req_ready : m1_req_ready;
      end
      check($sformatf("accept_m%0d", n), got, 1'b1);
      @(posedge clk); #1;
      if (n == 0) m0_req_valid = 1'b0; else m1_req_valid = 1'b0;
    end
  endtask

  // Downstream slave: random backpressure, request checking, and read
  // responses after a random latency (some beyond the timeout).
  task automatic slave_model();
    bit            hold = 1'b0;
    logic [AW-1:0] h_addr;
    logic          h_write;
    logic [DW-1:0] h_wdata;
    while (!stim_done) begin
      @(posedge clk); #1;
      s_req_ready = ($urandom_range(0, 9) < 7);
      s_rsp_valid = 1'b0;
      @(negedge clk);
      if (hold && s_req_valid) begin
        check("backpressure_addr", s_req_addr, h_addr);
        check("backpressure_write", s_req_write, h_write);
        check("backpressure_wdata", s_req_wdata, h_wdata);
      end
      hold = 1'b0;
      if (s_req_valid && !s_req_ready) begin
        hold = 1'b1; h_addr = s_req_addr; h_write = s_req_write; h_wdata = s_req_wdata;
      end else if (s_req_valid && s_req_ready) begin
        req_t r;
        logic g;
        g = cur_gnt;
        check("ready_granted", g ? m1_req_ready : m0_req_ready, 1'b1);
        check("ready_other", g ? m0_req_ready : m1_req_ready, 1'b0);
        if ((g == 1'b0 && req_q0.size() == 0) || (g == 1'b1 && req_q1.size() == 0)) begin
          check("req_unexpected", 1, 0);
        end else begin
          r = (g == 1'b0) ? req_q0.pop_front() : req_q1.pop_front();
          check("req_addr", s_req_addr, r.addr);
          check("req_write", s_req_write, r.write);
          check("req_wdata", s_req_wdata, r.wdata);
          if (!r.write) begin
            int            d;
            logic [DW-1:0] data;
            rsp_t          e;
            d    = $urandom_range(0, 11);
            data = DW'($urandom);
            e.to   = (d > TO - 1);
            e.data = e.to ? {DW{1'b1}} : data;
            e.cyc  = cyc + 1 + (e.to ? TO - 1 : d);
            if (g == 1'b0) rsp_q0.push_back(e); else rsp_q1.push_back(e);
            @(posedge clk); #1;
            s_req_ready = 1'b0;
            repeat (d) begin @(posedge clk); #1; end
            s_rsp_valid = 1'b1;
            s_rsp_rdata = data;
            @(posedge clk); #1;
            s_rsp_valid = 1'b0;
          end
        end
      end
    end
    s_req_ready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit   seen;
    logic w;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_s_req_valid", s_req_valid, 0);
    check("rst_m0_req_ready", m0_req_ready, 0);
    check("rst_m1_req_ready", m1_req_ready, 0);
    check("rst_m0_rsp_valid", m0_rsp_valid, 0);
    check("rst_m1_rsp_valid", m1_rsp_valid, 0);
    check("rst_timeout_err", timeout_err, 0);
    check("rst_gnt_id", gnt_id, 0);
    @(negedge clk); #2 rst_n = 1'b1;

    fork
      begin
        fork
          drive_master(0, 60);
          drive_master(1, 60);
        join
        stim_done = 1'b1;
      end
      slave_model();
    join
    repeat (20) @(posedge clk);

    // Reset while a read is waiting for its response.
    @(posedge clk); #1;
    m0_req_valid = 1'b1; m0_req_write = 1'b0; m0_req_addr = 16'h0040; s_req_ready = 1'b1;
    seen = 1'b0;
    for (int w2 = 0; w2 < 10 && !seen; w2++) begin
      @(negedge clk);
      seen = s_req_valid;
    end
    check("rst_test_issue", seen, 1'b1);
    @(posedge clk); #1;
    m0_req_valid = 1'b0; s_req_ready = 1'b0;
    @(posedge clk); #2;
    check("rsp_state_busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check("async_rst_busy", busy, 0);
    check("async_rst_s_req_valid", s_req_valid, 0);
    check("async_rst_m0_req_ready", m0_req_ready, 0);
    check("async_rst_m0_rsp_valid", m0_rsp_valid, 0);
    check("async_rst_m1_rsp_valid", m1_rsp_valid, 0);
    check("async_rst_timeout_err", timeout_err, 0);
    check("async_rst_gnt_id", gnt_id, 0);
    repeat (2) @(posedge clk);
    @(negedge clk); #2 rst_n = 1'b1;

    // First tie after reset goes to master 0 under either policy.
    @(posedge clk); #1;
    m0_req_valid = 1'b1; m0_req_write = 1'b1; m0_req_addr = 16'h0010; m0_req_wdata = 16'hA5A5;
    m1_req_valid = 1'b1; m1_req_write = 1'b1; m1_req_addr = 16'h0020; m1_req_wdata = 16'h5A5A;
    @(negedge clk);
    @(negedge clk);
    check("post_rst_tie_busy", busy, 1'b1);
    check("post_rst_tie_gnt", gnt_id, 1'b0);
    @(posedge clk); #1;
    s_req_ready = 1'b1;

    // Four ties in a row with both masters held requesting.
    for (int i = 0; i < 4; i++) begin
      seen = 1'b0;
      w = 1'b0;
      for (int k = 0; k < 10 && !seen; k++) begin
        @(negedge clk);
        if (m0_req_ready || m1_req_ready) begin
          seen = 1'b1;
          w = m1_req_ready;
        end
      end
      check("tie_seen", seen, 1'b1);
`ifdef VJTAG_ARB_RR_EN
      check($sformatf("tie_rr_%0d", i), w, (i == 0 || i == 2) ? 1'b0 : 1'b1);
`else
      check($sformatf("tie_fixed_%0d", i), w, 1'b0);
`endif
      @(posedge clk);
    end
    #1;
    m0_req_valid = 1'b0; m1_req_valid = 1'b0; s_req_ready = 1'b0;
    repeat (5) @(posedge clk);

    check("req_q0_drained", req_q0.size(), 0);
    check("req_q1_drained", req_q1.size(), 0);
    check("rsp_q0_drained", rsp_q0.size(), 0);
    check("rsp_q1_drained", rsp_q1.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
